// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous 512x32 RAM port between the CPU path and a loader/debug port
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   cpu_req_i/we_i/addr_i/wdata_i  CPU access request, held until cpu_ack_o
//   cpu_ack_o, cpu_rdata_o         one-cycle completion pulse and read data
//   cpu_stall_o                    cpu_req_i & ~cpu_ack_o, to the control unit
//   ldr_*                          same handshake for the loader/debug port
//   ldr_lock_i                     loader asks for bounded burst priority
//   ram_addr_o/data_o/we_o         registered RAM command
//   ram_q_i                        registered RAM read output
module mem_port_arbiter #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_ack_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    input  logic              ldr_req_i,
    input  logic              ldr_we_i,
    input  logic [ADDR_W-1:0] ldr_addr_i,
    input  logic [DATA_W-1:0] ldr_wdata_i,
    output logic              ldr_ack_o,
    output logic [DATA_W-1:0] ldr_rdata_o,
    input  logic              ldr_lock_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    output logic              ram_we_o,
    input  logic [DATA_W-1:0] ram_q_i
);
    localparam int CW = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] BMAX = CW'(BURST_MAX);

    typedef enum logic [1:0] {SLOT_NONE, SLOT_CPU, SLOT_LDR} slot_e;

    slot_e             slot_q, slot_d;
    logic              last_ldr_q, last_ldr_d;
    logic [CW-1:0]     burst_q, burst_d;
    logic              cpu_ack_q, ldr_ack_q;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic              cpu_ok, ldr_ok, ldr_pri;

    // slot_q is the outstanding flag: the port issued last edge is masked until its
    // ack rises. A requester updates req/addr as soon as it sees its ack, so the edge
    // closing the ack cycle already carries its next access (1 access per 2 cycles).
    always_comb begin
        cpu_ok     = cpu_req_i && slot_q != SLOT_CPU;
        ldr_ok     = ldr_req_i && slot_q != SLOT_LDR;
        ldr_pri    = ldr_lock_i ? burst_q != BMAX : !last_ldr_q;
        slot_d     = (cpu_ok && !(ldr_ok && ldr_pri)) ? SLOT_CPU : ldr_ok ? SLOT_LDR : SLOT_NONE;
        last_ldr_d = slot_d == SLOT_NONE ? last_ldr_q : slot_d == SLOT_LDR;
        burst_d    = (slot_d == SLOT_CPU || !ldr_lock_i) ? '0 :
                     (slot_d == SLOT_LDR && cpu_req_i && burst_q != BMAX) ? burst_q + CW'(1) : burst_q;
        ram_we_d   = slot_d == SLOT_CPU ? cpu_we_i : slot_d == SLOT_LDR ? ldr_we_i : 1'b0;
        ram_addr_d = slot_d == SLOT_CPU ? cpu_addr_i : slot_d == SLOT_LDR ? ldr_addr_i : ram_addr_q;
        ram_data_d = slot_d == SLOT_CPU ? cpu_wdata_i : slot_d == SLOT_LDR ? ldr_wdata_i : ram_data_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q     <= SLOT_NONE;
            last_ldr_q <= 1'b1;
            burst_q    <= '0;
            cpu_ack_q  <= 1'b0;
            ldr_ack_q  <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
        end else begin
            slot_q     <= slot_d;
            last_ldr_q <= last_ldr_d;
            burst_q    <= burst_d;
            cpu_ack_q  <= slot_q == SLOT_CPU;
            ldr_ack_q  <= slot_q == SLOT_LDR;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
        end
    end

    assign cpu_ack_o   = cpu_ack_q;
    assign ldr_ack_o   = ldr_ack_q;
    assign cpu_rdata_o = ram_q_i;
    assign ldr_rdata_o = ram_q_i;
    assign cpu_stall_o = cpu_req_i & ~cpu_ack_q;
    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_data_o  = ram_data_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a behavioural RAM and reference model
module tb_mem_port_arbiter;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int BM = 4;

    typedef struct packed {logic we; logic [AW-1:0] a; logic [DW-1:0] d;} acc_t;
    typedef struct {int cyc; logic rd; logic [DW-1:0] d;} exp_t;
    typedef struct {int cyc; int p;} log_t;

    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;

    logic          cpu_req = 0, cpu_we = 0, ldr_req = 0, ldr_we = 0, ldr_lock = 0;
    logic [AW-1:0] cpu_addr = 0, ldr_addr = 0;
    logic [DW-1:0] cpu_wdata = 0, ldr_wdata = 0;
    logic          cpu_ack, ldr_ack, cpu_stall, ram_we;
    logic [DW-1:0] cpu_rdata, ldr_rdata, ram_data, ram_q;
    logic [AW-1:0] ram_addr;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_ack_o(cpu_ack), .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
        .ldr_req_i(ldr_req), .ldr_we_i(ldr_we), .ldr_addr_i(ldr_addr), .ldr_wdata_i(ldr_wdata),
        .ldr_ack_o(ldr_ack), .ldr_rdata_o(ldr_rdata), .ldr_lock_i(ldr_lock),
        .ram_addr_o(ram_addr), .ram_data_o(ram_data), .ram_we_o(ram_we), .ram_q_i(ram_q)
    );

    // behavioural single-port synchronous RAM, read-before-write
    logic [DW-1:0] mem [512];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    int total = 0, bad = 0;
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // reference model state
    int            cyc = 0;
    logic [DW-1:0] ref_mem [512];
    int            m_prev = 0, m_burst = 0;
    logic          m_last_ldr = 1, m_iss = 0, m_we = 0, pw = 0;
    logic [AW-1:0] m_a, pa;
    logic [DW-1:0] m_d, pd;
    exp_t          expq [2][$];

    // each edge: free ports (not granted on the previous edge) compete; the model
    // decides the winner from the arbitration rules and predicts its ack one edge later
    always @(posedge clk) begin
        int   win;
        logic cf, lf;
        acc_t t;
        cyc++;
        if (!rst_n) begin
            m_prev = 0; m_burst = 0; m_last_ldr = 1; m_iss = 0; m_we = 0; pw = 0;
        end else begin
            if (pw) ref_mem[pa] = pd;
            pw = 0;
            cf = cpu_req && m_prev != 1;
            lf = ldr_req && m_prev != 2;
            if (cf && lf) win = ldr_lock ? (m_burst < BM ? 2 : 1) : (m_last_ldr ? 1 : 2);
            else win = cf ? 1 : lf ? 2 : 0;
            if (win == 1 || !ldr_lock) m_burst = 0;
            else if (win == 2 && cpu_req && m_burst < BM) m_burst++;
            m_iss = win != 0;
            m_we = 0;
            if (win != 0) begin
                t = win == 1 ? acc_t'{cpu_we, cpu_addr, cpu_wdata} : acc_t'{ldr_we, ldr_addr, ldr_wdata};
                m_we = t.we; m_a = t.a; m_d = t.d;
                expq[win-1].push_back('{cyc + 1, !t.we, ref_mem[t.a]});
                if (t.we) begin pw = 1; pa = t.a; pd = t.d; end
                m_last_ldr = win == 2;
            end
            m_prev = win;
        end
    end

    // monitor: pops the scoreboard whenever an ack appears
    log_t          ack_log [$];
    int            stall_cnt = 0, we_cnt = 0;
    logic [DW-1:0] last_rd [2];
    always @(negedge clk) begin
        logic          a;
        logic [DW-1:0] r;
        exp_t          e;
        if (cpu_stall) stall_cnt++;
        if (ram_we) we_cnt++;
        chk("stall", cpu_stall, cpu_req & ~cpu_ack);
        if (rst_n) begin
            chk("ram_we", ram_we, m_iss & m_we);
            if (m_iss) chk("ram_addr", ram_addr, m_a);
            if (m_iss && m_we) chk("ram_data", ram_data, m_d);
            for (int p = 0; p < 2; p++) begin
                a = p == 1 ? ldr_ack : cpu_ack;
                r = p == 1 ? ldr_rdata : cpu_rdata;
                if (a) begin
                    ack_log.push_back('{cyc, p});
                    last_rd[p] = r;
                    if (expq[p].size() == 0) chk(p == 1 ? "ldr_ack_spurious" : "cpu_ack_spurious", a, 0);
                    else begin
                        e = expq[p].pop_front();
                        chk(p == 1 ? "ldr_ack_cyc" : "cpu_ack_cyc", cyc, e.cyc);
                        if (e.rd) chk(p == 1 ? "ldr_rdata" : "cpu_rdata", r, e.d);
                    end
                end else if (expq[p].size() > 0 && expq[p][0].cyc <= cyc) begin
                    chk(p == 1 ? "ldr_ack_missing" : "cpu_ack_missing", a, 1);
                    void'(expq[p].pop_front());
                end
            end
        end
    end

    // requester drivers: hold until ack, present the next access in the ack cycle
    acc_t tx_cpu [$], tx_ldr [$];
    int   pct_c = 100, pct_l = 100, cpu_pres = 0;
    logic rand_lock = 0;
    initial begin
        acc_t t;
        forever begin
            @(posedge clk);
            #1;
            if (cpu_req && cpu_ack) cpu_req = 0;
            if (ldr_req && ldr_ack) ldr_req = 0;
            if (!cpu_req && tx_cpu.size() > 0 && $urandom_range(0, 99) < pct_c) begin
                t = tx_cpu.pop_front();
                cpu_req = 1; cpu_we = t.we; cpu_addr = t.a; cpu_wdata = t.d; cpu_pres = cyc;
            end
            if (!ldr_req && tx_ldr.size() > 0 && $urandom_range(0, 99) < pct_l) begin
                t = tx_ldr.pop_front();
                ldr_req = 1; ldr_we = t.we; ldr_addr = t.a; ldr_wdata = t.d;
            end
            if (rand_lock) ldr_lock = 1'($urandom_range(0, 1));
        end
    end

    task automatic wait_idle(input string n);
        int k = 0;
        while ((tx_cpu.size() > 0 || tx_ldr.size() > 0 || cpu_req || ldr_req ||
                expq[0].size() > 0 || expq[1].size() > 0) && k < 5000) begin
            @(posedge clk);
            k++;
        end
        chk({n, "_timeout"}, k >= 5000, 0);
        repeat (2) @(posedge clk);
    endtask

    function automatic acc_t rnd_acc(input int amax);
        return '{1'($urandom_range(0, 1)), AW'($urandom_range(0, amax)), $urandom};
    endfunction

    initial begin
        int k, run, max_run, same;
        for (int i = 0; i < 512; i++) begin
            mem[i] <= DW'(i) * 32'h9E3779B9;
            ref_mem[i] = DW'(i) * 32'h9E3779B9;
        end
        mem[16] <= 32'hDEADBEEF;
        ref_mem[16] = 32'hDEADBEEF;

        #2 cpu_req = 1;
        #1 chk("rst_stall_follows_req", cpu_stall, 1);
        cpu_req = 0;
        #1 chk("rst_stall_low", cpu_stall, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_data", ram_data, 0);
        chk("rst_acks", {cpu_ack, ldr_ack}, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        repeat (2) @(posedge clk);

        // single CPU read of preloaded word
        stall_cnt = 0;
        ack_log.delete();
        tx_cpu.push_back('{1'b0, 9'h010, 32'h0});
        wait_idle("cpu_rd");
        chk("cpu_rd_data", last_rd[0], 32'hDEADBEEF);
        chk("cpu_rd_acks", ack_log.size(), 1);
        if (ack_log.size() == 1) chk("cpu_rd_latency", ack_log[0].cyc - cpu_pres, 2);
        chk("cpu_rd_stall_cycles", stall_cnt, 2);

        // loader write then CPU read back
        we_cnt = 0;
        tx_ldr.push_back('{1'b1, 9'h1F0, 32'h12345678});
        wait_idle("ldr_wr");
        chk("ldr_wr_we_cycles", we_cnt, 1);
        tx_cpu.push_back('{1'b0, 9'h1F0, 32'h0});
        wait_idle("cpu_rb");
        chk("cpu_readback", last_rd[0], 32'h12345678);

        // continuous contention, no lock then lock
        for (int l = 0; l < 2; l++) begin
            ldr_lock = 1'(l);
            ack_log.delete();
            for (int i = 0; i < 8; i++) begin
                tx_cpu.push_back(rnd_acc(31));
                tx_ldr.push_back(rnd_acc(31));
            end
            wait_idle(l == 1 ? "lock" : "rr");
            chk(l == 1 ? "lock_acks" : "rr_acks", ack_log.size(), 16);
            same = 0; run = 0; max_run = 0;
            for (int i = 0; i < ack_log.size(); i++) begin
                if (i > 0 && ack_log[i].p == ack_log[i-1].p) same++;
                run = ack_log[i].p == 1 ? run + 1 : 0;
                if (run > max_run) max_run = run;
            end
            if (ack_log.size() == 16) chk(l == 1 ? "lock_span" : "rr_span", ack_log[15].cyc - ack_log[0].cyc, 15);
            chk(l == 1 ? "lock_cpu_wait_bound" : "rr_cpu_wait_bound", max_run <= BM, 1);
            if (l == 0) chk("rr_alternate", same, 0);
        end
        ldr_lock = 0;

        // back-to-back CPU reads: second issue two edges after the first
        ack_log.delete();
        tx_cpu.push_back('{1'b0, 9'h010, 32'h0});
        tx_cpu.push_back('{1'b0, 9'h011, 32'h0});
        wait_idle("b2b");
        chk("b2b_acks", ack_log.size(), 2);
        if (ack_log.size() == 2) chk("b2b_spacing", ack_log[1].cyc - ack_log[0].cyc, 2);

        // reset during an in-flight CPU write
        tx_cpu.push_back('{1'b1, 9'h0A5, 32'hCAFEF00D});
        k = 0;
        do begin @(negedge clk); k++; end while (!ram_we && k < 50);
        chk("rst_wr_issued", ram_we, 1);
        #2 rst_n = 0;
        expq[0].delete();
        expq[1].delete();
        #1 chk("rst_mid_we_drop", ram_we, 0);
        chk("rst_mid_addr", ram_addr, 0);
        chk("rst_mid_data", ram_data, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid_no_ack", cpu_ack, 0);
        end
        @(posedge clk);
        #3 rst_n = 1;
        wait_idle("rst_reissue");
        tx_cpu.push_back('{1'b0, 9'h0A5, 32'h0});
        wait_idle("rst_rb");
        chk("rst_reissue_data", last_rd[0], 32'hCAFEF00D);

        // randomized traffic with random idle gaps and lock toggling
        pct_c = 60; pct_l = 45; rand_lock = 1;
        for (int i = 0; i < 150; i++) begin
            tx_cpu.push_back(rnd_acc(15));
            tx_ldr.push_back(rnd_acc(15));
        end
        wait_idle("random");
        rand_lock = 0;
        ldr_lock = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
